// File: rtl/conv_feeder.sv
// conv_feeder: stores one filter (up to 5x5) and one image (up to 8x8) of
// signed 8-bit samples, then on request streams the filter, a one-cycle gap
// and the NxN image toward a convolution engine. It finishes by collecting
// N*N result strobes, or by giving up after 255 silent cycles.
module conv_feeder (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [5:0]        wr_addr,
  input  logic signed [7:0] wr_data,
  input  logic              start,
  input  logic              cfg_filter_size,
  input  logic [3:0]        cfg_image_size,
  input  logic              cfg_pad_mode,
  input  logic              cfg_act_mode,
  input  logic              conv_out_valid,
  output logic              filter_valid,
  output logic              image_valid,
  output logic              filter_size,
  output logic [3:0]        image_size,
  output logic              pad_mode,
  output logic              act_mode,
  output logic signed [7:0] in_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {S_IDLE, S_FILT, S_GAP, S_IMG, S_WAIT} state_t;

  state_t      state_reg, state_next;
  logic [2:0]  row_reg, row_next;
  logic [2:0]  col_reg, col_next;
  logic [6:0]  res_cnt_reg, res_cnt_next;
  logic [7:0]  idle_cnt_reg, idle_cnt_next;
  logic        filt5_reg, pad_reg, act_reg;
  logic [3:0]  n_reg;

  logic signed [7:0] filter_mem [0:24];
  logic signed [7:0] image_mem  [0:63];

  // Derived control terms
  logic        cfg_ok, accept;
  logic [2:0]  f_last, n_last;
  logic [6:0]  n_ext, nn, res_inc;
  logic        filt_last, img_last, res_done, timeout;
  logic [4:0]  faddr;
  logic [5:0]  iaddr;

  // Next values of the registered outputs
  logic filter_valid_next, image_valid_next, first_filt;
  logic busy_next, done_next, err_next;

  assign cfg_ok    = (cfg_image_size >= 4'd3) && (cfg_image_size <= 4'd8);
  assign accept    = (state_reg == S_IDLE) && start && cfg_ok;
  assign f_last    = filt5_reg ? 3'd4 : 3'd2;
  assign n_last    = n_reg[2:0] - 3'd1;        // N=8 wraps to 7 as intended
  assign n_ext     = {3'b000, n_reg};
  assign nn        = n_ext * n_ext;
  assign res_inc   = res_cnt_reg + {6'd0, conv_out_valid};
  assign filt_last = (row_reg == f_last) && (col_reg == f_last);
  assign img_last  = (row_reg == n_last) && (col_reg == n_last);
  assign res_done  = (res_inc >= nn);
  assign timeout   = !conv_out_valid && (idle_cnt_reg == 8'd254);
  // Filter buffer is laid out on a fixed 5-wide pitch, image on an 8-wide pitch
  assign faddr     = ({2'b00, row_reg} * 5'd5) + {2'b00, col_reg};
  assign iaddr     = {row_reg, col_reg};

  // Buffer writes: only while idle and in range; contents never reset
  always_ff @(posedge clk) begin
    if (wr_en && !busy) begin
      if (wr_sel)
        image_mem[wr_addr] <= wr_data;
      else if (wr_addr < 6'd25)
        filter_mem[wr_addr[4:0]] <= wr_data;
    end
  end

  // State, scan counters, result/watchdog counters and latched config
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      row_reg      <= 3'd0;
      col_reg      <= 3'd0;
      res_cnt_reg  <= 7'd0;
      idle_cnt_reg <= 8'd0;
      filt5_reg    <= 1'b0;
      n_reg        <= 4'd0;
      pad_reg      <= 1'b0;
      act_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      row_reg      <= row_next;
      col_reg      <= col_next;
      res_cnt_reg  <= res_cnt_next;
      idle_cnt_reg <= idle_cnt_next;
      if (accept) begin
        filt5_reg <= cfg_filter_size;
        n_reg     <= cfg_image_size;
        pad_reg   <= cfg_pad_mode;
        act_reg   <= cfg_act_mode;
      end
    end
  end

  // Next-state logic, including the row/column scan and result counting
  always_comb begin
    state_next    = state_reg;
    row_next      = row_reg;
    col_next      = col_reg;
    res_cnt_next  = (state_reg == S_IDLE) ? 7'd0 : res_inc;
    idle_cnt_next = 8'd0;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          state_next = S_FILT;
          row_next   = 3'd0;
          col_next   = 3'd0;
        end
      end
      S_FILT: begin
        if (filt_last) begin
          state_next = S_GAP;
          row_next   = 3'd0;
          col_next   = 3'd0;
        end else if (col_reg == f_last) begin
          col_next = 3'd0;
          row_next = row_reg + 3'd1;
        end else begin
          col_next = col_reg + 3'd1;
        end
      end
      S_GAP: state_next = S_IMG;
      S_IMG: begin
        if (img_last) begin
          state_next = S_WAIT;
          row_next   = 3'd0;
          col_next   = 3'd0;
        end else if (col_reg == n_last) begin
          col_next = 3'd0;
          row_next = row_reg + 3'd1;
        end else begin
          col_next = col_reg + 3'd1;
        end
      end
      S_WAIT: begin
        idle_cnt_next = conv_out_valid ? 8'd0 : idle_cnt_reg + 8'd1;
        if (res_done || timeout) begin
          state_next    = S_IDLE;
          res_cnt_next  = 7'd0;
          idle_cnt_next = 8'd0;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Output decode: values the output registers take at the next edge
  always_comb begin
    filter_valid_next = (state_reg == S_FILT);
    image_valid_next  = (state_reg == S_IMG);
    first_filt        = (state_reg == S_FILT) && (row_reg == 3'd0) && (col_reg == 3'd0);
    busy_next         = (state_next != S_IDLE);
    done_next         = (state_reg == S_WAIT) && res_done;
    err_next          = ((state_reg == S_IDLE) && start && !cfg_ok) ||
                        ((state_reg == S_WAIT) && !res_done && timeout);
  end

  // Output registers; the buffer read is folded into the in_data register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filter_valid <= 1'b0;
      image_valid  <= 1'b0;
      filter_size  <= 1'b0;
      image_size   <= 4'd0;
      pad_mode     <= 1'b0;
      act_mode     <= 1'b0;
      in_data      <= 8'sd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      filter_valid <= filter_valid_next;
      image_valid  <= image_valid_next;
      filter_size  <= first_filt ? filt5_reg : 1'b0;
      image_size   <= first_filt ? n_reg : 4'd0;
      pad_mode     <= first_filt ? pad_reg : 1'b0;
      act_mode     <= first_filt ? act_reg : 1'b0;
      if (filter_valid_next)
        in_data <= filter_mem[faddr];
      else if (image_valid_next)
        in_data <= image_mem[iaddr];
      else
        in_data <= 8'sd0;
      busy <= busy_next;
      done <= done_next;
      err  <= err_next;
    end
  end

endmodule

// File: tb/tb_conv_feeder.sv
// tb_conv_feeder: directed sequence with randomized buffer contents, config
// and result-strobe timing. Expected streams are built from a plain array
// copy of both buffers and the row-major scan rules.
module tb_conv_feeder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en, wr_sel;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;
  logic       start, cfg_filter_size, cfg_pad_mode, cfg_act_mode;
  logic [3:0] cfg_image_size;
  logic       conv_out_valid;
  logic       filter_valid, image_valid, filter_size, pad_mode, act_mode;
  logic [3:0] image_size;
  logic [7:0] in_data;
  logic       busy, done, err;

  int vectors = 0;
  int fails   = 0;

  logic [7:0] filt_m [25];
  logic [7:0] img_m  [64];

  conv_feeder dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_addr(wr_addr), .wr_data(wr_data), .start(start),
    .cfg_filter_size(cfg_filter_size), .cfg_image_size(cfg_image_size),
    .cfg_pad_mode(cfg_pad_mode), .cfg_act_mode(cfg_act_mode),
    .conv_out_valid(conv_out_valid), .filter_valid(filter_valid),
    .image_valid(image_valid), .filter_size(filter_size),
    .image_size(image_size), .pad_mode(pad_mode), .act_mode(act_mode),
    .in_data(in_data), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_fv"}, 32'(filter_valid), 0);
    chk({tag, "_iv"}, 32'(image_valid), 0);
    chk({tag, "_data"}, 32'(in_data), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_cfg"}, {26'd0, filter_size, image_size, pad_mode}, 0);
    chk({tag, "_act"}, 32'(act_mode), 0);
  endtask

  // One write attempt; the model applies only the in-range, idle writes
  task automatic wr(input bit sel, input logic [5:0] addr, input logic [7:0] data);
    wr_en = 1'b1; wr_sel = sel; wr_addr = addr; wr_data = data;
    if (sel) img_m[addr] = data;
    else if (addr < 25) filt_m[addr] = data;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic bad_start(input logic [3:0] sz);
    start = 1'b1; cfg_image_size = sz; cfg_filter_size = 1'b1;
    tick();
    start = 1'b0;
    chk("bad_err_pulse", 32'(err), 1);
    chk("bad_busy", 32'(busy), 0);
    chk("bad_fv", 32'(filter_valid), 0);
    tick();
    chk("bad_err_clear", 32'(err), 0);
    chk("bad_busy2", 32'(busy), 0);
    chk("bad_valids", {30'd0, filter_valid, image_valid}, 0);
  endtask

  // mode 0: normal completion; 1: one strobe short, expect timeout;
  // 2: interfere during image phase and reset at image cycle 5
  task automatic run(input bit f5, input int n, input bit pad, input bit act, input int mode);
    logic [7:0] expq[$];
    int fsz, nn, sent, cap, target, remaining;
    fsz = f5 ? 5 : 3;
    nn  = n * n;
    for (int r = 0; r < fsz; r++)
      for (int c = 0; c < fsz; c++) expq.push_back(filt_m[r*5 + c]);
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++) expq.push_back(img_m[r*8 + c]);
    sent   = 0;
    cap    = (mode == 1) ? nn - 2 : nn - 1;
    target = (mode == 1) ? nn - 1 : nn;

    start = 1'b1; cfg_filter_size = f5; cfg_image_size = 4'(n);
    cfg_pad_mode = pad; cfg_act_mode = act; conv_out_valid = 1'b0;
    tick();
    start = 1'b0;
    cfg_filter_size = 1'($urandom); cfg_image_size = 4'($urandom);
    cfg_pad_mode = 1'($urandom); cfg_act_mode = 1'($urandom);
    chk("acc_busy", 32'(busy), 1);
    chk("acc_fv", 32'(filter_valid), 0);
    chk("acc_done", 32'(done), 0);

    for (int k = 0; k < fsz*fsz; k++) begin
      tick();
      chk("filt_fv", 32'(filter_valid), 1);
      chk("filt_iv", 32'(image_valid), 0);
      chk("filt_data", 32'(in_data), 32'(expq.pop_front()));
      chk("filt_fsize", 32'(filter_size), (k == 0) ? 32'(f5) : 0);
      chk("filt_isize", 32'(image_size), (k == 0) ? 32'(n) : 0);
      chk("filt_pad_act", {30'd0, pad_mode, act_mode}, (k == 0) ? {30'd0, pad, act} : 0);
    end

    tick();
    chk("gap_valids", {30'd0, filter_valid, image_valid}, 0);
    chk("gap_data", 32'(in_data), 0);
    chk("gap_busy", 32'(busy), 1);

    for (int k = 0; k < nn; k++) begin
      if (mode != 2 && sent < cap && $urandom_range(0, 3) == 0) begin
        conv_out_valid = 1'b1; sent++;
      end else begin
        conv_out_valid = 1'b0;
      end
      if (mode == 2 && k == 2) begin
        wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 6'd9; wr_data = ~img_m[9];
        start = 1'b1; cfg_image_size = 4'd3;
      end
      tick();
      wr_en = 1'b0; start = 1'b0;
      chk("img_iv", 32'(image_valid), 1);
      chk("img_fv", 32'(filter_valid), 0);
      chk("img_data", 32'(in_data), 32'(expq.pop_front()));
      chk("img_cfg", {27'd0, filter_size, image_size}, 0);
      if (mode == 2 && k == 5) begin
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_now");
        tick();
        chk_all_zero("rst_hold");
        rst_n = 1'b1;
        for (int j = 0; j < 4; j++) begin
          conv_out_valid = (j < 2);
          tick();
          chk_all_zero("post_rst");
        end
        conv_out_valid = 1'b0;
        return;
      end
    end

    remaining = target - sent;
    for (int g = 0; remaining > 0; g++) begin
      conv_out_valid = ($urandom_range(0, 2) == 0) || (g > 40);
      if (conv_out_valid) remaining--;
      tick();
      if (remaining == 0 && mode == 0) begin
        chk("done_pulse", 32'(done), 1);
        chk("done_busy", 32'(busy), 0);
        chk("done_err", 32'(err), 0);
      end else begin
        chk("wait_done", 32'(done), 0);
        chk("wait_busy", 32'(busy), 1);
        chk("wait_err", 32'(err), 0);
      end
    end
    conv_out_valid = 1'b0;

    if (mode == 1) begin
      for (int j = 2; j <= 256; j++) begin
        tick();
        chk("tmo_err", 32'(err), (j == 256) ? 1 : 0);
      end
      chk("tmo_busy", 32'(busy), 0);
      chk("tmo_done", 32'(done), 0);
      tick();
      chk("tmo_err_clear", 32'(err), 0);
      chk("tmo_idle_done", 32'(done), 0);
    end
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; cfg_filter_size = 1'b0; cfg_image_size = '0;
    cfg_pad_mode = 1'b0; cfg_act_mode = 1'b0; conv_out_valid = 1'b0;
    tick(); tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Full random contents, then the known 3x3 / 4x4 pattern on top
    for (int a = 0; a < 25; a++) wr(1'b0, 6'(a), 8'($urandom));
    for (int a = 0; a < 64; a++) wr(1'b1, 6'(a), 8'($urandom));
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) wr(1'b0, 6'(r*5 + c), 8'(r*3 + c + 1));
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) wr(1'b1, 6'(r*8 + c), 8'(10 + r*4 + c));

    // Strobes while idle must not count
    for (int j = 0; j < 3; j++) begin
      conv_out_valid = 1'b1;
      tick();
      chk("idle_strobe_busy", 32'(busy), 0);
      chk("idle_strobe_done", 32'(done), 0);
    end
    conv_out_valid = 1'b0;

    run(1'b0, 4, 1'b1, 1'b0, 0);
    run(1'b1, 8, 1'b0, 1'b1, 0);   // back-to-back after done

    bad_start(4'd9);
    bad_start(4'd2);
    bad_start(4'd15);

    // Random writes, some to filter addresses beyond 24
    for (int j = 0; j < 40; j++)
      wr(1'($urandom), 6'($urandom), 8'($urandom));

    for (int j = 0; j < 4; j++)
      run(1'($urandom), $urandom_range(3, 8), 1'($urandom), 1'($urandom), 0);

    run(1'b0, 4, 1'b0, 1'b0, 1);
    run(1'b1, 4, 1'b1, 1'b1, 2);
    run(1'($urandom), 8, 1'($urandom), 1'($urandom), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
